// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and defaults for the SDRAM arbiter
package sdram_arb_pkg;

  localparam int ADDR_W_DEF = 25;
  localparam int DATA_W_DEF = 16;
  localparam int BURST_LEN  = 32;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  typedef enum logic {
    GNT_CPU,
    GNT_VID
  } grant_e;

endpackage

// File: rtl/sdram_arb_pick.sv
// rtl/sdram_arb_pick.sv - combinational winner select between CPU and video requests
// SDRAM_ARB_RR_EN selects round-robin; default build gives video fixed priority.
module sdram_arb_pick (
  input  logic cpu_req,
  input  logic vid_req,
  input  logic last_vid,
  output logic gnt_valid,
  output logic gnt_vid
);

  always_comb begin
    gnt_valid = cpu_req | vid_req;
`ifdef SDRAM_ARB_RR_EN
    gnt_vid = vid_req & (~cpu_req | ~last_vid);
`else
    // last_vid only steers the no-request case, where gnt_vid is a don't-care
    gnt_vid = vid_req | (~cpu_req & last_vid);
`endif
  end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - shares one sdram_ctl port between CPU words and video bursts
// Arbitration policy set by SDRAM_ARB_RR_EN (round-robin) inside sdram_arb_pick.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              ctl_write_en,
  output logic              ctl_burst_en,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_data_in,
  output logic              ctl_refresh_data,
  input  logic [DATA_W-1:0] ctl_data_out,
  input  logic              ctl_data_ready,
  input  logic              ctl_mem_ready,
  output logic              busy
);

  state_e              state_q, state_d;
  grant_e              grant_q, grant_d;
  grant_e              last_grant_q, last_grant_d;
  logic                write_en_q, write_en_d;
  logic                burst_en_q, burst_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_in_q, data_in_d;
  logic                refresh_q, refresh_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                vid_ack_q, vid_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                busy_q, busy_d;
  logic                pick_valid, pick_vid;

  sdram_arb_pick u_pick (
    .cpu_req  (cpu_req),
    .vid_req  (vid_req),
    .last_vid (last_grant_q == GNT_VID),
    .gnt_valid(pick_valid),
    .gnt_vid  (pick_vid)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    write_en_d   = write_en_q;
    burst_en_d   = burst_en_q;
    addr_d       = addr_q;
    data_in_d    = data_in_q;
    cpu_rdata_d  = cpu_rdata_q;
    refresh_d    = 1'b0;
    cpu_ack_d    = 1'b0;
    vid_ack_d    = 1'b0;

    case (state_q)
      S_INIT: begin
        if (ctl_mem_ready) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (pick_valid) begin
          state_d   = S_ISSUE;
          refresh_d = 1'b1;
          if (pick_vid) begin
            grant_d    = GNT_VID;
            write_en_d = 1'b0;
            burst_en_d = 1'b1;
            addr_d     = vid_addr;
            data_in_d  = '0;
          end else begin
            grant_d    = GNT_CPU;
            write_en_d = cpu_we;
            burst_en_d = 1'b0;
            addr_d     = cpu_addr;
            data_in_d  = cpu_wdata;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Acks are registered here so they line up with the S_DONE cycle
        if (ctl_data_ready) begin
          state_d = S_DONE;
          if (grant_q == GNT_CPU) begin
            cpu_ack_d = 1'b1;
            if (!write_en_q) cpu_rdata_d = ctl_data_out;
          end else begin
            vid_ack_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        last_grant_d = grant_q;
      end
      default: state_d = S_INIT;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_INIT;
      grant_q      <= GNT_VID;
      last_grant_q <= GNT_VID;
      write_en_q   <= 1'b0;
      burst_en_q   <= 1'b0;
      addr_q       <= '0;
      data_in_q    <= '0;
      refresh_q    <= 1'b0;
      cpu_ack_q    <= 1'b0;
      vid_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      write_en_q   <= write_en_d;
      burst_en_q   <= burst_en_d;
      addr_q       <= addr_d;
      data_in_q    <= data_in_d;
      refresh_q    <= refresh_d;
      cpu_ack_q    <= cpu_ack_d;
      vid_ack_q    <= vid_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign ctl_write_en     = write_en_q;
  assign ctl_burst_en     = burst_en_q;
  assign ctl_addr         = addr_q;
  assign ctl_data_in      = data_in_q;
  assign ctl_refresh_data = refresh_q;
  assign cpu_ack          = cpu_ack_q;
  assign vid_ack          = vid_ack_q;
  assign cpu_rdata        = cpu_rdata_q;
  assign busy             = busy_q;

endmodule
